// File: rtl/pool2x2_stream.sv
// pool2x2_stream: 2x2 stride-2 max/average pooling over a raster pixel stream with valid/ready handshakes.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   mode                   0 = max, 1 = average, latched on the accepted (0,0) beat
//   in_valid/in_ready      input handshake, in_ready = !out_valid || out_ready
//   in_sof                 start of frame; on any position other than (0,0) it restarts the frame
//   in_data                CH signed DW-bit channels, channel c at [c*DW +: DW]
//   out_valid/out_ready    output handshake, out_data/out_last held while stalled
//   out_data               pooled pixel, same packing as in_data
//   out_last               marks the last pooled pixel of a frame
//   frame_err              one-cycle pulse after an in_sof beat that was not at (0,0)
module pool2x2_stream #(
  parameter int CH = 16,
  parameter int DW = 8,
  parameter int IN_WIDTH = 8,
  parameter int IN_HEIGHT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [CH*DW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic             out_last,
  output logic             frame_err
);
  localparam int CW = IN_WIDTH > 2 ? $clog2(IN_WIDTH) : 1;
  localparam int RW = IN_HEIGHT > 2 ? $clog2(IN_HEIGHT) : 1;
  localparam int LBD = IN_WIDTH / 2;
  localparam int LW = LBD > 1 ? $clog2(LBD) : 1;
  logic [CW-1:0] col, pc;
  logic [RW-1:0] row, pr;
  logic [LW-1:0] li;
  logic mode_q, accept, restart, col_end, row_end;
  logic signed [DW:0] left [CH];
  logic signed [DW:0] lb [LBD][CH];
  logic signed [DW:0] xw [CH];
  logic signed [DW:0] pw [CH];
  logic [CH*DW-1:0] res;
  // Max keeps the larger operand; average accumulates a sum that is rounded only at the end.
  function automatic logic signed [DW+1:0] op(input logic signed [DW+1:0] a, input logic signed [DW+1:0] b, input logic m);
    return m ? a + b : (a > b ? a : b);
  endfunction
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  // An in_sof away from (0,0) forces this beat to be treated as the first pixel of a new frame.
  assign restart = in_sof && (col != '0 || row != '0);
  assign pc = restart ? '0 : col;
  assign pr = restart ? '0 : row;
  assign li = LW'(pc >> 1);
  assign col_end = pc == CW'(IN_WIDTH - 1);
  assign row_end = pr == RW'(IN_HEIGHT - 1);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0] x;
    logic signed [DW+1:0] p1, p2, r;
    logic unused;
    assign x = in_data[c*DW +: DW];
    assign p1 = op({left[c][DW], left[c]}, {{2{x[DW-1]}}, x}, mode_q);
    assign p2 = op({lb[li][c][DW], lb[li][c]}, p1, mode_q);
    // Adding 2 before the arithmetic shift rounds the quarter-sum half up.
    assign r = p2 + (DW+2)'(2);
    assign res[c*DW +: DW] = mode_q ? r[DW+1:2] : p2[DW-1:0];
    assign xw[c] = {x[DW-1], x};
    assign pw[c] = p1[DW:0];
    assign unused = ^{r[1:0], p2[DW+1:DW], p1[DW+1]};
  end
  // Datapath storage needs no reset: every entry is written before it is read within a frame.
  always_ff @(posedge clk) begin
    if (accept && !pc[0])
      for (int c = 0; c < CH; c++) left[c] <= xw[c];
    if (accept && !pr[0] && pc[0])
      for (int c = 0; c < CH; c++) lb[li][c] <= pw[c];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      mode_q <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept && restart;
      if (accept) begin
        if (pc == '0 && pr == '0) mode_q <= mode;
        col <= col_end ? '0 : pc + 1'b1;
        row <= col_end ? (row_end ? '0 : pr + 1'b1) : pr;
      end
      if (accept && pr[0] && pc[0]) begin
        out_valid <= 1'b1;
        out_data <= res;
        out_last <= col_end && row_end;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream: randomized and directed checks of pool2x2_stream against a frame-level pooling model.
module tb_pool2x2_stream;
  logic clk = 0, rst = 1, mode = 0, in_valid = 0, in_sof = 0, out_ready = 1;
  logic in_ready, out_valid, out_last, frame_err;
  logic [15:0] in_data = '0;
  logic [15:0] out_data;
  int checks = 0, errors = 0, err_cnt = 0, k = 0;
  bit exp_err = 0, fmode = 0, rnd = 0;
  int pix [16][2];
  int qd0 [$], qd1 [$], log0 [$], log1 [$];
  bit ql [$], logl [$];

  pool2x2_stream #(.CH(2), .DW(8), .IN_WIDTH(4), .IN_HEIGHT(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_sof(in_sof), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pool(input int a, input int b, input int c, input int d, input bit m);
    int s, mx;
    s = a + b + c + d + 2;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    if (d > mx) mx = d;
    return m ? (s >= 0 ? s / 4 : -((-s + 3) / 4)) : mx;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      qd0.delete(); qd1.delete(); ql.delete();
      k = 0;
      exp_err = 0;
    end else begin
      chk("frame_err", frame_err, exp_err);
      if (frame_err) err_cnt++;
      chk("out_valid", out_valid, qd0.size() != 0);
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && qd0.size() != 0) begin
        chk("out_ch0", $signed(out_data[7:0]), qd0[0]);
        chk("out_ch1", $signed(out_data[15:8]), qd1[0]);
        chk("out_last", out_last, ql[0]);
        if (out_ready) begin
          log0.push_back($signed(out_data[7:0]));
          log1.push_back($signed(out_data[15:8]));
          logl.push_back(out_last);
          void'(qd0.pop_front()); void'(qd1.pop_front()); void'(ql.pop_front());
        end
      end
      exp_err = 0;
      if (in_valid && in_ready) begin
        if (in_sof && k != 0) begin
          exp_err = 1;
          k = 0;
        end
        if (k == 0) fmode = mode;
        pix[k][0] = $signed(in_data[7:0]);
        pix[k][1] = $signed(in_data[15:8]);
        if ((k / 4) % 2 == 1 && k % 2 == 1) begin
          qd0.push_back(pool(pix[k-5][0], pix[k-4][0], pix[k-1][0], pix[k][0], fmode));
          qd1.push_back(pool(pix[k-5][1], pix[k-4][1], pix[k-1][1], pix[k][1], fmode));
          ql.push_back(k == 15);
        end
        k = (k + 1) % 16;
      end
    end
  end

  task automatic beat(input int d0, input int d1, input bit sof, input bit m);
    bit acc;
    logic [7:0] b0, b1;
    b0 = d0[7:0];
    b1 = d1[7:0];
    in_valid = 1; in_sof = sof; mode = m; in_data = {b1, b0};
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd) out_ready = $urandom_range(0, 3) != 0;
      if (acc) break;
      if (t > 1000) begin
        chk("beat_timeout", 0, 1);
        break;
      end
    end
    in_valid = 0; in_sof = 0;
  endtask

  task automatic drain(input int n);
    out_ready = 1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int base, held, e0[4], e1[4];
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    // Max, continuous
    base = log0.size();
    for (int i = 0; i < 16; i++) beat(i, -i, i == 0, 0);
    drain(4);
    e0 = '{5, 7, 13, 15};
    e1 = '{0, -2, -8, -10};
    chk("max_count", log0.size() - base, 4);
    for (int i = 0; i < 4 && base + i < log0.size(); i++) begin
      chk("max_lit_ch0", log0[base+i], e0[i]);
      chk("max_lit_ch1", log1[base+i], e1[i]);
      chk("max_lit_last", logl[base+i], i == 3);
    end
    // Average rounding and saturating extremes
    base = log0.size();
    for (int i = 0; i < 16; i++) begin
      int r, c, blk, v;
      bit first;
      r = i / 4; c = i % 4;
      blk = (r / 2) * 2 + c / 2;
      first = (r % 2 == 0) && (c % 2 == 0);
      v = blk == 0 ? (first ? 1 : 2) : blk == 1 ? (first ? -1 : -2) : blk == 2 ? 127 : -128;
      beat(v, $urandom_range(0, 255) - 128, i == 0, i == 0);
    end
    drain(4);
    e0 = '{2, -2, 127, -128};
    chk("avg_count", log0.size() - base, 4);
    for (int i = 0; i < 4 && base + i < log0.size(); i++) chk("avg_lit_ch0", log0[base+i], e0[i]);
    // Backpressure on the first result
    base = log0.size();
    out_ready = 0;
    fork
      for (int i = 0; i < 16; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, i == 0, 0);
      begin
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
          @(negedge clk);
          seen = out_valid;
        end
        chk("bp_result_seen", seen, 1);
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 0);
          chk("bp_hold", out_data, held);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain(4);
    chk("bp_count", log0.size() - base, 4);
    // Mode latched at (0,0), then next frame in max mode
    base = log0.size();
    for (int i = 0; i < 16; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, i == 0, i < 3);
    for (int i = 0; i < 16; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, i == 0, 0);
    drain(4);
    chk("mode_count", log0.size() - base, 8);
    // Early sof on the sixth beat
    base = log0.size();
    held = err_cnt;
    for (int i = 0; i < 5; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, i == 0, 0);
    beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1, 1);
    for (int i = 0; i < 15; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 0, 0);
    drain(4);
    chk("sof_err_pulses", err_cnt - held, 1);
    chk("sof_count", log0.size() - base, 4);
    if (log0.size() > base) chk("sof_last", logl[log0.size()-1], 1);
    // Reset mid-frame
    for (int i = 0; i < 9; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, i == 0, 1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_last", out_last, 0);
    @(posedge clk);
    #1;
    base = log0.size();
    for (int i = 0; i < 16; i++) beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 0, 0);
    drain(4);
    chk("midrst_count", log0.size() - base, 4);
    if (log0.size() > base) chk("midrst_last", logl[log0.size()-1], 1);
    // Random traffic, gaps, backpressure, mode changes and stray sof
    rnd = 1;
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1 out_ready = $urandom_range(0, 3) != 0;
      end
      beat($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           i % 16 == 0 ? 1'($urandom_range(0, 1)) : $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
    end
    rnd = 0;
    drain(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
